static_seg_sequencer: RTL and testbench

- Sequences burst accesses to the static data segment on behalf of two requesters, e.g. the instruction unit (static load/store) and the static-init copier.
- Arbitrates round-robin and latches the winner's segment base, burst length and direction.
- Walks a 20-bit static-pointer offset from 0 upward, presenting base+offset to the memory port one beat per mem_ack.
- Owns the static-pointer increment sequencing: the offset counter is the block's internal pointer, exported for debug and for mirroring.

---
 rtl/static_seg_sequencer.sv | 139 +++++++++++++
 tb/tb_static_seg_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/static_seg_sequencer.sv
// Round-robin burst sequencer for the static data segment: two requesters share one
// memory port. The winner's base/len/dir are latched and the offset pointer walks 0..len-1.
module static_seg_sequencer #(
    parameter int unsigned AW = 20,
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req,
    input  logic [AW-1:0] req_base0,
    input  logic [AW-1:0] req_base1,
    input  logic [LW-1:0] req_len0,
    input  logic [LW-1:0] req_len1,
    input  logic [1:0]    req_we,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          aborted,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    input  logic          mem_ack,
    output logic [AW-1:0] cur_offset,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          lrr_q, lrr_d;
    logic          we_q, we_d;
    logic          aborted_q, aborted_d;
    logic [AW-1:0] base_q, base_d;
    logic [LW-1:0] len_q, len_d;
    logic [AW-1:0] offset_q, offset_d;

    logic          sel_w;
    logic [LW-1:0] len_w;
    logic [AW-1:0] offset_inc;

    // State register; reset mid-burst drops everything without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sel_q     <= 1'b0;
            lrr_q     <= 1'b1;
            we_q      <= 1'b0;
            aborted_q <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            offset_q  <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            lrr_q     <= lrr_d;
            we_q      <= we_d;
            aborted_q <= aborted_d;
            base_q    <= base_d;
            len_q     <= len_d;
            offset_q  <= offset_d;
        end
    end

    // Next-state: arbitration, latching and offset pointer sequencing.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        lrr_d      = lrr_q;
        we_d       = we_q;
        aborted_d  = aborted_q;
        base_d     = base_q;
        len_d      = len_q;
        offset_d   = offset_q;
        sel_w      = (req == 2'b11) ? ~lrr_q : req[1];
        len_w      = sel_w ? req_len1 : req_len0;
        offset_inc = offset_q + AW'(1);

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    sel_d     = sel_w;
                    base_d    = sel_w ? req_base1 : req_base0;
                    len_d     = len_w;
                    we_d      = req_we[sel_w];
                    offset_d  = '0;
                    aborted_d = 1'b0;
                    state_d   = (len_w == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ack) begin
                    offset_d = offset_inc;
                    if (offset_inc == AW'(len_q)) begin
                        aborted_d = 1'b0;
                        state_d   = S_FINISH;
                    end else if (!req[sel_q]) begin
                        aborted_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                lrr_d   = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode only registered state.
    always_comb begin
        gnt        = 2'b00;
        done       = 2'b00;
        aborted    = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        cur_offset = offset_q;
        busy       = (state_q != S_IDLE);

        if (state_q != S_IDLE) begin
            gnt = sel_q ? 2'b10 : 2'b01;
        end
        if (state_q == S_ISSUE) begin
            mem_req  = 1'b1;
            mem_addr = base_q + offset_q;
            mem_we   = we_q;
        end
        if (state_q == S_FINISH) begin
            done    = sel_q ? 2'b10 : 2'b01;
            aborted = aborted_q;
        end
    end

endmodule

// File: tb/tb_static_seg_sequencer.sv
// Directed bench for static_seg_sequencer; inputs driven and outputs sampled on negedge.
module tb_static_seg_sequencer;

    localparam int unsigned AW = 20;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [AW-1:0] req_base0, req_base1;
    logic [LW-1:0] req_len0, req_len1;
    logic [1:0]    req_we;
    logic [1:0]    gnt, done;
    logic          aborted, mem_req, mem_we, mem_ack, busy;
    logic [AW-1:0] mem_addr, cur_offset;

    int n_checks = 0;
    int n_pass   = 0;

    static_seg_sequencer #(.AW(AW), .LW(LW)) dut (
        .clk(clk), .reset(reset), .req(req),
        .req_base0(req_base0), .req_base1(req_base1),
        .req_len0(req_len0), .req_len1(req_len1), .req_we(req_we),
        .gnt(gnt), .done(done), .aborted(aborted),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_ack(mem_ack), .cur_offset(cur_offset), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] wexp [3];
        logic [1:0]    exp_g;
        int            n;

        reset = 1'b0; req = 2'b00; req_we = 2'b00; mem_ack = 1'b0;
        req_base0 = '0; req_base1 = '0; req_len0 = '0; req_len1 = '0;
        cyc();
        check("rst_gnt",    32'(gnt), 32'(0));
        check("rst_done",   32'(done), 32'(0));
        check("rst_memreq", 32'(mem_req), 32'(0));
        check("rst_busy",   32'(busy), 32'(0));
        check("rst_off",    32'(cur_offset), 32'(0));
        check("rst_abort",  32'(aborted), 32'(0));
        cyc();
        reset = 1'b1;

        // Single 3-beat read burst, ack tied high.
        req_base0 = 20'h00100; req_len0 = 8'd3; req_we = 2'b00; mem_ack = 1'b1;
        req = 2'b01;
        cyc();
        check("s_gnt",  32'(gnt), 32'(2'b01));
        check("s_busy", 32'(busy), 32'(1));
        check("s_we",   32'(mem_we), 32'(0));
        for (int b = 0; b < 3; b++) begin
            check("s_req",  32'(mem_req), 32'(1));
            check("s_addr", 32'(mem_addr), 32'(20'h00100 + b));
            cyc();
        end
        check("s_done",  32'(done), 32'(2'b01));
        check("s_abort", 32'(aborted), 32'(0));
        check("s_fgnt",  32'(gnt), 32'(2'b01));
        check("s_freq",  32'(mem_req), 32'(0));
        req = 2'b00;
        cyc();
        check("s_idle_gnt", 32'(gnt), 32'(0));
        check("s_idle_done", 32'(done), 32'(0));
        check("s_idle_busy", 32'(busy), 32'(0));
        check("s_off", 32'(cur_offset), 32'(3));

        // Tie then alternation, starting from reset.
        do_reset();
        req_base0 = 20'h00200; req_base1 = 20'h00300;
        req_len0 = 8'd1; req_len1 = 8'd1;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (gnt == 2'b00 && n < 20) begin cyc(); n++; end
            check("alt_gnt", 32'(gnt), 32'(exp_g));
            check("alt_addr", 32'(mem_addr), (i % 2 == 0) ? 32'h200 : 32'h300);
            n = 0;
            while (done == 2'b00 && n < 20) begin cyc(); n++; end
            check("alt_done", 32'(done), 32'(exp_g));
            req = (i == 3) ? 2'b00 : (req & ~exp_g);
            cyc();
            if (i < 3) req = 2'b11;
        end
        cyc();

        // Wrap with stalls, write direction, requester 1 alone.
        wexp[0] = 20'hFFFFE; wexp[1] = 20'hFFFFF; wexp[2] = 20'h00000;
        req_base1 = 20'hFFFFE; req_len1 = 8'd3; req_we = 2'b10; mem_ack = 1'b0;
        req = 2'b10;
        cyc();
        check("w_gnt", 32'(gnt), 32'(2'b10));
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 3; k++) begin
                check("w_addr", 32'(mem_addr), 32'(wexp[b]));
                check("w_req",  32'(mem_req), 32'(1));
                check("w_we",   32'(mem_we), 32'(1));
                mem_ack = (k == 2);
                cyc();
            end
        end
        mem_ack = 1'b0;
        check("w_done",  32'(done), 32'(2'b10));
        check("w_abort", 32'(aborted), 32'(0));
        req = 2'b00;
        cyc();
        check("w_off", 32'(cur_offset), 32'(3));

        // Zero length: grant and done together for one cycle, no beats.
        req_len0 = 8'd0; req_we = 2'b00; mem_ack = 1'b1;
        req = 2'b01;
        cyc();
        check("z_gnt",  32'(gnt), 32'(2'b01));
        check("z_done", 32'(done), 32'(2'b01));
        check("z_req",  32'(mem_req), 32'(0));
        req = 2'b00;
        cyc();
        check("z_gnt2", 32'(gnt), 32'(0));
        check("z_req2", 32'(mem_req), 32'(0));
        check("z_off",  32'(cur_offset), 32'(0));

        // Abort: req[0] dropped before the 2nd beat is accepted.
        req_base0 = 20'h00400; req_len0 = 8'd5;
        req = 2'b01;
        cyc();
        check("a_addr0", 32'(mem_addr), 32'h400);
        cyc();
        check("a_addr1", 32'(mem_addr), 32'h401);
        req = 2'b00;
        cyc();
        check("a_req",   32'(mem_req), 32'(0));
        check("a_done",  32'(done), 32'(2'b01));
        check("a_abort", 32'(aborted), 32'(1));
        cyc();
        check("a_off",  32'(cur_offset), 32'(2));
        check("a_busy", 32'(busy), 32'(0));

        // Asynchronous reset during the 2nd beat of a 4-beat burst.
        req_base0 = 20'h00500; req_len0 = 8'd4;
        req = 2'b01;
        cyc();
        cyc();
        check("r_addr", 32'(mem_addr), 32'h501);
        #2 reset = 1'b0;
        #1;
        check("r_gnt",  32'(gnt), 32'(0));
        check("r_req",  32'(mem_req), 32'(0));
        check("r_busy", 32'(busy), 32'(0));
        check("r_off",  32'(cur_offset), 32'(0));
        check("r_done", 32'(done), 32'(0));
        req = 2'b00;
        cyc();
        check("r_done2", 32'(done), 32'(0));
        reset = 1'b1;
        req_len0 = 8'd1; req_len1 = 8'd1;
        req = 2'b11;
        cyc();
        check("r_tie", 32'(gnt), 32'(2'b01));
        n = 0;
        while (done == 2'b00 && n < 20) begin cyc(); n++; end
        check("r_tdone", 32'(done), 32'(2'b01));
        req = 2'b00;
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
